// File: rtl/mem_pkg.sv
// Shared definitions for the single-port RAM controller: controller states,
// default RAM geometry and the burst-length field width.
package mem_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/resp_fifo2.sv
// Two-entry response FIFO carrying a read word plus its end-of-burst marker.
// The head entry stays put until it is popped, so the output is stable under backpressure.
module resp_fifo2 #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          last,
  output logic [1:0]    count
);

  logic [DW-1:0] data_q [2];
  logic          last_q [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count_q;
  logic          pop_ok;
  logic          push_ok;

  assign pop_ok  = pop && (count_q != 2'd0);
  assign push_ok = push && ((count_q != 2'd2) || pop_ok);

  // NOTE: the storage is reset as well, because the read word must read as zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push_ok) begin
        data_q[wr_ptr] <= push_data;
        last_q[wr_ptr] <= push_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
    end
  end

  assign valid = (count_q != 2'd0);
  assign data  = data_q[rd_ptr];
  assign last  = last_q[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/mem_port_ctrl.sv
// Request/response front end for a single-port synchronous RAM: single-word
// writes and credit-limited burst reads of up to 16 words.
module mem_port_ctrl
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [DW-1:0]    req_wdata,
  output logic             wr_done,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [DW-1:0]    resp_data,
  output logic             resp_last,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_din,
  input  logic [DW-1:0]    ram_dout
);

  state_t         state, next_state;
  logic [AW-1:0]  rd_addr;
  logic [AW-1:0]  addr_q;
  logic [LEN_W:0] remaining;
  logic           inflight;
  logic           inflight_last;
  logic [1:0]     fifo_count;
  logic [1:0]     credit;
  logic           credit_free;
  logic           pop;
  logic           accept;
  logic           issue;

  // Credit counts words buffered plus the one read whose data is on ram_dout now;
  // a same-cycle pop returns its credit immediately, which keeps bursts at full rate.
  assign pop         = resp_valid && resp_ready;
  assign credit      = fifo_count + 2'(inflight);
  assign credit_free = (credit < 2'd2) || pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          next_state = req_we ? WRITE : READ;
        end
      end
      WRITE: next_state = IDLE;
      READ: begin
        if (credit_free) begin
          issue = 1'b1;
          if (remaining == (LEN_W+1)'(1)) next_state = DRAIN;
        end
      end
      DRAIN: if (pop && resp_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_we        <= 1'b0;
      ram_din       <= '0;
      addr_q        <= '0;
      wr_done       <= 1'b0;
      rd_addr       <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      ram_we        <= accept && req_we;
      wr_done       <= (state == WRITE);
      inflight      <= issue;
      inflight_last <= issue && (remaining == (LEN_W+1)'(1));
      if (accept && req_we) begin
        addr_q  <= req_addr;
        ram_din <= req_wdata;
      end
      if (accept && !req_we) begin
        rd_addr   <= req_addr;
        remaining <= (LEN_W+1)'(req_len) + (LEN_W+1)'(1);
      end
      if (issue) begin
        addr_q    <= rd_addr;
        rd_addr   <= rd_addr + AW'(1);
        remaining <= remaining - (LEN_W+1)'(1);
      end
    end
  end

  // During READ the pending address goes straight to the RAM; otherwise the last used one is held.
  assign ram_addr = (state == READ) ? rd_addr : addr_q;

  resp_fifo2 #(.DW(DW)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (ram_dout),
    .push_last (inflight_last),
    .pop       (pop),
    .valid     (resp_valid),
    .data      (resp_data),
    .last      (resp_last),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural one-cycle-latency RAM.
module tb_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [3:0]  req_len = '0;
  logic [15:0] req_wdata = '0;
  logic        wr_done;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [15:0] resp_data;
  logic        resp_last;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  logic [15:0] mem [256];

  int total = 0;
  int bad = 0;

  logic [15:0] got_data[$];
  logic        got_last[$];
  int          got_cyc[$];
  int          stall_seen;
  int          stall_bad;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  mem_port_ctrl #(.AW(8), .DW(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_wdata  (req_wdata),
    .wr_done    (wr_done),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  // Single write used for preloading; starts and ends 1 time unit after a rising edge, in IDLE.
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    @(posedge clk); #1;
  endtask

  // Issues a burst read and collects popped words; cycle 1 is the cycle after the accept edge.
  // resp_ready is low in cycles [stall_at, stall_at+stall_n). abort_after>0 returns early.
  task automatic run_read(input logic [7:0] a, input logic [3:0] len,
                          input int stall_at, input int stall_n, input int abort_after);
    logic        done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;
    int          cyc = 1;
    got_data.delete(); got_last.delete(); got_cyc.delete();
    stall_seen = 0; stall_bad = 0;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = len;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!done && cyc <= 100) begin
      resp_ready = !(cyc >= stall_at && cyc < stall_at + stall_n);
      if (resp_valid) begin
        if (prev_stall) begin
          stall_seen++;
          if (resp_data !== prev_data || resp_last !== prev_last) stall_bad++;
        end
        if (resp_ready) begin
          got_data.push_back(resp_data);
          got_last.push_back(resp_last);
          got_cyc.push_back(cyc);
          if (resp_last) done = 1'b1;
          if (abort_after > 0 && got_data.size() == abort_after) return;
        end
      end
      prev_stall = resp_valid && !resp_ready;
      prev_data  = resp_data;
      prev_last  = resp_last;
      @(posedge clk); #1;
      cyc++;
    end
    resp_ready = 1'b1;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL read_timeout addr=%h: got %0d words, burst never ended", a, got_data.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    total++;
    if ({req_ready, resp_valid, resp_last, ram_we, wr_done} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl: {rdy,rv,rl,we,done}=%b want 10000",
               {req_ready, resp_valid, resp_last, ram_we, wr_done});
    end
    total++;
    if (ram_addr !== 8'h00 || ram_din !== 16'h0000 || resp_data !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data: addr=%h din=%h rdata=%h want 00 0000 0000", ram_addr, ram_din, resp_data);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: rdy=%b rv=%b want 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_write();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 16'hBEEF;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL write_ready: req_ready=%b want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h10 || ram_din !== 16'hBEEF || wr_done !== 1'b0) begin
      bad++;
      $display("FAIL write_cycle: we=%b addr=%h din=%h done=%b want 1 10 beef 0", ram_we, ram_addr, ram_din, wr_done);
    end
    @(posedge clk); #1;
    total++;
    if (ram_we !== 1'b0 || wr_done !== 1'b1 || ram_addr !== 8'h10 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL write_done: we=%b done=%b addr=%h rdy=%b want 0 1 10 1", ram_we, wr_done, ram_addr, req_ready);
    end
    @(posedge clk); #1;
    total++;
    if (wr_done !== 1'b0) begin
      bad++; $display("FAIL write_pulse: wr_done=%b want 0", wr_done);
    end
    run_read(8'h10, 4'd0, 0, 0, 0);
    total++;
    if (got_data.size() != 1 || got_data[0] !== 16'hBEEF || got_last[0] !== 1'b1) begin
      bad++;
      $display("FAIL write_readback: n=%0d data=%h last=%b want 1 beef 1",
               got_data.size(), got_data.size() > 0 ? got_data[0] : 16'hxxxx,
               got_last.size() > 0 ? got_last[0] : 1'bx);
    end
  endtask

  task automatic test_burst();
    wr(8'h20, 16'd1); wr(8'h21, 16'd2); wr(8'h22, 16'd3); wr(8'h23, 16'd4);
    run_read(8'h20, 4'd3, 0, 0, 0);
    total++;
    if (got_data.size() != 4) begin
      bad++; $display("FAIL burst_count: got %0d words want 4", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== 16'(i + 1) || got_last[i] !== (i == 3) || got_cyc[i] != i + 3) begin
        bad++;
        $display("FAIL burst_word%0d: data=%0d last=%b cyc=%0d want %0d %b %0d",
                 i, got_data[i], got_last[i], got_cyc[i], i + 1, (i == 3), i + 3);
      end
    end
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL burst_idle: rdy=%b rv=%b want 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp [4];
    exp[0] = 16'hC0FE; exp[1] = 16'hC0FF; exp[2] = 16'hC000; exp[3] = 16'hC001;
    wr(8'hFE, exp[0]); wr(8'hFF, exp[1]); wr(8'h00, exp[2]); wr(8'h01, exp[3]);
    run_read(8'hFE, 4'd3, 0, 0, 0);
    total++;
    if (got_data.size() != 4) begin
      bad++; $display("FAIL wrap_count: got %0d words want 4", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== exp[i]) begin
        bad++; $display("FAIL wrap_word%0d: data=%h want %h", i, got_data[i], exp[i]);
      end
    end
    total++;
    if (ram_addr !== 8'h01 || ram_we !== 1'b0) begin
      bad++; $display("FAIL wrap_hold: addr=%h we=%b want 01 0", ram_addr, ram_we);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i), 16'(16'h1000 + i));
    run_read(8'h40, 4'd15, 6, 5, 0);
    total++;
    if (got_data.size() != 16) begin
      bad++; $display("FAIL bp_count: got %0d words want 16", got_data.size());
    end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== 16'(16'h1000 + i) || got_last[i] !== (i == 15)) begin
        bad++;
        $display("FAIL bp_word%0d: data=%h last=%b want %h %b", i, got_data[i], got_last[i], 16'(16'h1000 + i), (i == 15));
      end
    end
    total++;
    if (stall_seen != 5 || stall_bad != 0) begin
      bad++; $display("FAIL bp_stable: stalled_cycles=%0d changed=%0d want 5 0", stall_seen, stall_bad);
    end
    total++;
    if (got_cyc.size() != 16 || got_cyc[got_cyc.size() - 1] != 23) begin
      bad++;
      $display("FAIL bp_latency: last pop cycle=%0d want 23",
               got_cyc.size() > 0 ? got_cyc[got_cyc.size() - 1] : -1);
    end
  endtask

  task automatic test_reset_mid_burst();
    int stray = 0;
    run_read(8'h40, 4'd7, 0, 0, 3);
    reset_n = 1'b0;
    #2;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || ram_we !== 1'b0 || resp_data !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset: rv=%b rdy=%b we=%b rdata=%h want 0 1 0 0000", resp_valid, req_ready, ram_we, resp_data);
    end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) stray++;
      @(posedge clk); #1;
    end
    total++;
    if (stray != 0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_quiet: stray_valid_cycles=%0d rdy=%b want 0 1", stray, req_ready);
    end
    run_read(8'h42, 4'd0, 0, 0, 0);
    total++;
    if (got_data.size() != 1 || got_data[0] !== 16'h1002 || got_last[0] !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_read: n=%0d data=%h want 1 1002", got_data.size(),
               got_data.size() > 0 ? got_data[0] : 16'hxxxx);
    end
  endtask

  task automatic test_busy();
    int          accept_cyc = 0;
    int          last_pop = 0;
    int          we_cnt = 0;
    int          done_cnt = 0;
    logic        drop = 1'b0;
    logic [15:0] words[$];
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20; req_len = 4'd3;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 8'h30; req_wdata = 16'h5A5A;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (drop) begin req_valid = 1'b0; req_we = 1'b0; drop = 1'b0; end
      if (ram_we) we_cnt++;
      if (wr_done) done_cnt++;
      if (resp_valid) begin
        words.push_back(resp_data);
        if (resp_last) last_pop = cyc;
      end
      if (req_valid && req_ready && accept_cyc == 0) begin
        accept_cyc = cyc;
        drop = 1'b1;
      end
      @(posedge clk); #1;
    end
    total++;
    if (accept_cyc != 7 || last_pop != 6 || words.size() != 4) begin
      bad++;
      $display("FAIL busy_order: accept_cyc=%0d last_pop=%0d words=%0d want 7 6 4", accept_cyc, last_pop, words.size());
    end
    total++;
    if (we_cnt != 1 || done_cnt != 1) begin
      bad++; $display("FAIL busy_once: ram_we_cycles=%0d wr_done_pulses=%0d want 1 1", we_cnt, done_cnt);
    end
    run_read(8'h30, 4'd0, 0, 0, 0);
    total++;
    if (got_data.size() != 1 || got_data[0] !== 16'h5A5A) begin
      bad++;
      $display("FAIL busy_readback: n=%0d data=%h want 1 5a5a", got_data.size(),
               got_data.size() > 0 ? got_data[0] : 16'hxxxx);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst();
    test_wrap();
    test_backpressure();
    test_reset_mid_burst();
    test_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter AW, default 8, RAM address width (256 words).
REQ-002 SHALL have parameter DW, default 16, RAM data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = single-word write, 0 = burst read.
REQ-008 SHALL have port req_addr  input  AW  start address.
REQ-009 SHALL have port req_len  input  4  burst length minus one (0..15 means 1..16 words); ignored for writes.
REQ-010 SHALL have port req_wdata  input  DW  write data.
REQ-011 SHALL have port wr_done  output  1  one-cycle pulse after a write reaches the RAM.
REQ-012 SHALL have port resp_valid  output  1  read word available.
REQ-013 SHALL have port resp_ready  input  1  consumer takes the word.
REQ-014 SHALL have port resp_data  output  DW  read word.
REQ-015 SHALL have port resp_last  output  1  marks the final word of a burst.
REQ-016 SHALL have port ram_we  output  1  RAM write enable.
REQ-017 SHALL have port ram_addr  output  AW  RAM address.
REQ-018 SHALL have port ram_din  output  DW  RAM write data.
REQ-019 SHALL have port ram_dout  input  DW  RAM read data, valid exactly one cycle after ram_addr is presented.

Function
REQ-020 SHALL implement the FSM states IDLE, WRITE, READ and DRAIN.
REQ-021 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-022 SHALL, on write accept, go IDLE->WRITE, register ram_we=1, ram_addr=req_addr and ram_din=req_wdata for exactly one cycle, pulse wr_done the following cycle, and return to IDLE.
REQ-023 SHALL, on read accept, go IDLE->READ, latch the start address and the remaining count req_len+1, and issue one address per cycle while credit is available.
REQ-024 SHALL track credit as FIFO occupancy plus in-flight reads, which SHALL never exceed 2; no address is issued when credit is 2.
REQ-025 SHALL capture ram_dout into a 2-entry response FIFO one cycle after each issued address.
REQ-026 SHALL increment the issued address modulo 2^AW, so 0xFF wraps to 0x00 inside a burst.
REQ-027 SHALL go READ->DRAIN after issuing the last address, and DRAIN->IDLE when the last word is popped (resp_valid && resp_ready && resp_last).
REQ-028 SHALL drive resp_valid whenever the FIFO is non-empty, and SHALL keep resp_data and resp_last stable while resp_valid is high and resp_ready is low.
REQ-029 SHALL allow a simultaneous FIFO push and pop without data loss or change in occupancy.
REQ-030 SHALL drive ram_we=0 at all times outside WRITE; ram_addr and ram_din SHALL hold their last value when unused.
REQ-031 SHALL ignore req_valid when it is asserted while not in IDLE.
REQ-032 SHALL achieve a full-rate burst of N words with resp_ready held high in N+2 cycles from accept to last pop.

Reset
REQ-033 SHALL, while reset_n is low, force state=IDLE, req_ready=1, empty FIFO, credit=0, ram_we=0, ram_addr=0, ram_din=0, wr_done=0, resp_valid=0, resp_last=0, resp_data=0.
REQ-034 SHALL, on reset mid-burst or mid-write, discard all pending words with no partial response after reset is released.

Structure
REQ-035 SHALL place the FSM state encoding, AW/DW defaults and the length width in a shared package mem_pkg.
REQ-036 SHALL implement the 2-entry response FIFO as sub-module resp_fifo2; all other logic SHALL reside in mem_port_ctrl.

Verification
REQ-037 SHALL test a write: addr=0x10, wdata=0xBEEF -> ram_we high for one cycle with ram_addr=0x10 and ram_din=0xBEEF, then wr_done pulse; a 1-word read of 0x10 then returns 0xBEEF with resp_last=1.
REQ-038 SHALL test a full-rate burst: preload 0x20..0x23 = 1,2,3,4, req_len=3, resp_ready=1 -> resp_data 1,2,3,4 on consecutive cycles, resp_last only on 4, 6 cycles total.
REQ-039 SHALL test wrap-around: req_addr=0xFE, req_len=3 -> RAM addresses 0xFE, 0xFF, 0x00, 0x01 issued in order.
REQ-040 SHALL test backpressure: resp_ready low for 5 cycles during a 16-word burst -> no lost or duplicated words, data stable while stalled, credit never above 2.
REQ-041 SHALL test reset mid-burst: reset_n low after 3 words of 8 -> resp_valid=0 and req_ready=1 after release, with no stale words.
REQ-042 SHALL test a busy request: req_valid held during DRAIN -> not accepted until IDLE, then serviced once.
